// File: rtl/baud_gen_frac.sv
// -----------------------------------------------------------------------------
// baud_gen_frac
// Fractional (NCO) baud-rate generator for uart_rx / uart_tx.
// A phase accumulator adds INCR[rate] every enabled cycle; each carry out of
// the accumulator is one oversample tick. Every OVERSAMPLE oversample ticks
// form one bit: the mid-bit tick fires on the tick that ends the first half
// of the bit, and the baud tick fires on the tick that ends the bit.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      asynchronous reset, active-high
//   i_valid      enable; 0 freezes accumulator, counter and rate
//   i_rate_sel   requested rate index (0..3)
//   i_rate_load  1-cycle strobe capturing i_rate_sel
//   i_resync     1-cycle strobe zeroing the bit phase (RX start edge)
//   o_os_tick    1-cycle pulse at OVERSAMPLE*baud
//   o_mid_tick   1-cycle pulse at the mid-bit sample point
//   o_baud_tick  1-cycle pulse at the bit boundary
//   o_os_count   current oversample index within the bit
//   o_rate_cur   rate index currently driving the accumulator
//   o_rate_pend  a rate change is waiting for the next bit boundary
// -----------------------------------------------------------------------------
module baud_gen_frac #(
   parameter int unsigned CLK_FREQ     = 100000000,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned ACC_W        = 32,
   parameter int unsigned BAUD0        = 9600,
   parameter int unsigned BAUD1        = 19200,
   parameter int unsigned BAUD2        = 57600,
   parameter int unsigned BAUD3        = 115200,
   parameter int unsigned RATE_SEL_RST = 3
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_valid,
   input  logic [1:0]                    i_rate_sel,
   input  logic                          i_rate_load,
   input  logic                          i_resync,
   output logic                          o_os_tick,
   output logic                          o_mid_tick,
   output logic                          o_baud_tick,
   output logic [$clog2(OVERSAMPLE)-1:0] o_os_count,
   output logic [1:0]                    o_rate_cur,
   output logic                          o_rate_pend
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);

   // Rounded phase increment: round(baud * OVERSAMPLE * 2^ACC_W / CLK_FREQ).
   function automatic logic [63:0] calc_incr(input logic [63:0] baud);
      logic [63:0] num;
      num = (baud * 64'(OVERSAMPLE)) << ACC_W;
      return (num + 64'(CLK_FREQ / 32'd2)) / 64'(CLK_FREQ);
   endfunction

   localparam logic [63:0] INCR0 = calc_incr(64'(BAUD0));
   localparam logic [63:0] INCR1 = calc_incr(64'(BAUD1));
   localparam logic [63:0] INCR2 = calc_incr(64'(BAUD2));
   localparam logic [63:0] INCR3 = calc_incr(64'(BAUD3));

   localparam logic [1:0]       RATE_RST = 2'(RATE_SEL_RST);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 32'd1);
   localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'(OVERSAMPLE / 32'd2 - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   // Reject parameter sets that cannot produce a usable tick stream.
   if (INCR0 == 64'd0 || INCR1 == 64'd0 || INCR2 == 64'd0 || INCR3 == 64'd0) begin : g_bad_incr
      $error("baud_gen_frac: a rate table entry rounds to a zero increment");
   end
   if ((64'(BAUD0) * 64'(OVERSAMPLE) * 64'd2 > 64'(CLK_FREQ)) ||
       (64'(BAUD1) * 64'(OVERSAMPLE) * 64'd2 > 64'(CLK_FREQ)) ||
       (64'(BAUD2) * 64'(OVERSAMPLE) * 64'd2 > 64'(CLK_FREQ)) ||
       (64'(BAUD3) * 64'(OVERSAMPLE) * 64'd2 > 64'(CLK_FREQ))) begin : g_bad_baud
      $error("baud_gen_frac: oversample rate exceeds half the clock frequency");
   end
   if (OVERSAMPLE < 32'd4 || OVERSAMPLE > 32'd32 ||
       (OVERSAMPLE & (OVERSAMPLE - 32'd1)) != 32'd0) begin : g_bad_ovs
      $error("baud_gen_frac: OVERSAMPLE must be a power of 2 in 4..32");
   end
   if (RATE_SEL_RST > 32'd3) begin : g_bad_rst_sel
      $error("baud_gen_frac: RATE_SEL_RST out of range");
   end

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
   logic [1:0]       rate_cur_q, rate_cur_d;
   logic [1:0]       rate_lat_q, rate_lat_d;
   logic             rate_pend_q, rate_pend_d;
   logic             os_tick_q, os_tick_d;
   logic             mid_tick_q, mid_tick_d;
   logic             baud_tick_q, baud_tick_d;

   logic [ACC_W-1:0] incr_s;
   logic [ACC_W:0]   sum_s;
   logic             carry_s;

   // Increment for the active rate; the extra sum bit is the oversample carry.
   always_comb begin
      incr_s = INCR3[ACC_W-1:0];
      case (rate_cur_q)
         2'd0:    incr_s = INCR0[ACC_W-1:0];
         2'd1:    incr_s = INCR1[ACC_W-1:0];
         2'd2:    incr_s = INCR2[ACC_W-1:0];
         2'd3:    incr_s = INCR3[ACC_W-1:0];
         default: incr_s = INCR3[ACC_W-1:0];
      endcase
      sum_s   = {1'b0, acc_q} + {1'b0, incr_s};
      carry_s = sum_s[ACC_W];
   end

   // Next-state: resync beats enable; rate changes while running wait for the bit boundary.
   always_comb begin
      acc_d       = acc_q;
      os_cnt_d    = os_cnt_q;
      rate_cur_d  = rate_cur_q;
      rate_lat_d  = rate_lat_q;
      rate_pend_d = rate_pend_q;
      os_tick_d   = 1'b0;
      mid_tick_d  = 1'b0;
      baud_tick_d = 1'b0;
      if (i_resync) begin
         acc_d       = '0;
         os_cnt_d    = '0;
         rate_pend_d = 1'b0;
         // A simultaneous load wins over an older pending index.
         if (i_rate_load) begin
            rate_cur_d = i_rate_sel;
         end else if (rate_pend_q) begin
            rate_cur_d = rate_lat_q;
         end else begin
            rate_cur_d = rate_cur_q;
         end
      end else if (i_valid) begin
         acc_d       = sum_s[ACC_W-1:0];
         os_tick_d   = carry_s;
         mid_tick_d  = carry_s && (os_cnt_q == MID_CNT);
         baud_tick_d = carry_s && (os_cnt_q == LAST_CNT);
         if (carry_s) begin
            os_cnt_d = os_cnt_q + CNT_ONE;   // wraps naturally: OVERSAMPLE is 2^CNT_W
         end else begin
            os_cnt_d = os_cnt_q;
         end
         // Accumulator is not cleared on a rate switch, keeping the phase continuous.
         if (baud_tick_d && rate_pend_q) begin
            rate_cur_d  = rate_lat_q;
            rate_pend_d = 1'b0;
         end else begin
            rate_cur_d  = rate_cur_q;
         end
         if (i_rate_load) begin
            rate_lat_d  = i_rate_sel;
            rate_pend_d = 1'b1;
         end else begin
            rate_lat_d  = rate_lat_q;
         end
      end else begin
         // Idle: no bit in flight, so the new rate can take effect at once.
         if (i_rate_load) begin
            rate_cur_d  = i_rate_sel;
            rate_pend_d = 1'b0;
         end else begin
            rate_cur_d  = rate_cur_q;
         end
      end
   end

   // State and registered tick outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         acc_q       <= '0;
         os_cnt_q    <= '0;
         rate_cur_q  <= RATE_RST;
         rate_lat_q  <= RATE_RST;
         rate_pend_q <= 1'b0;
         os_tick_q   <= 1'b0;
         mid_tick_q  <= 1'b0;
         baud_tick_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         os_cnt_q    <= os_cnt_d;
         rate_cur_q  <= rate_cur_d;
         rate_lat_q  <= rate_lat_d;
         rate_pend_q <= rate_pend_d;
         os_tick_q   <= os_tick_d;
         mid_tick_q  <= mid_tick_d;
         baud_tick_q <= baud_tick_d;
      end
   end

   assign o_os_tick   = os_tick_q;
   assign o_mid_tick  = mid_tick_q;
   assign o_baud_tick = baud_tick_q;
   assign o_os_count  = os_cnt_q;
   assign o_rate_cur  = rate_cur_q;
   assign o_rate_pend = rate_pend_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// -----------------------------------------------------------------------------
// tb_baud_gen_frac
// Scoreboard bench for baud_gen_frac at 100 MHz, x16, default rate table.
// Stimulus pushes one expected record per upcoming oversample tick (interval
// window, index, rate, pending flag); the monitor pops one record per o_os_tick.
// Hand-computed increments: rate0 6597070 (651/652 clk), rate1 13194140
// (325/326), rate2 39582419 (108/109), rate3 79164837 (54/55). From a zeroed
// accumulator the first tick takes 652/326/109/55 additions respectively.
// -----------------------------------------------------------------------------
module tb_baud_gen_frac;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [1:0] rate_sel;
   logic       rate_load;
   logic       resync;
   logic       os_tick;
   logic       mid_tick;
   logic       baud_tick;
   logic [3:0] os_count;
   logic [1:0] rate_cur;
   logic       rate_pend;

   always #5 clk = ~clk;

   baud_gen_frac dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_valid     (valid),
      .i_rate_sel  (rate_sel),
      .i_rate_load (rate_load),
      .i_resync    (resync),
      .o_os_tick   (os_tick),
      .o_mid_tick  (mid_tick),
      .o_baud_tick (baud_tick),
      .o_os_count  (os_count),
      .o_rate_cur  (rate_cur),
      .o_rate_pend (rate_pend)
   );

   typedef struct {
      int lo;
      int hi;
      int cnt;
      int rate;
      int pend;
   } exp_t;

   exp_t q[$];
   int   total     = 0;
   int   bad       = 0;
   int   cyc       = 0;
   int   mark_cyc  = 0;
   int   mark_id   = 0;
   int   tick_seen = 0;
   int   mid_cyc   = 0;
   int   baud_cyc  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      total++;
      if (act < lo || act > hi) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
      end
   endtask

   // Monitor: every os tick is matched against the next expected record.
   initial begin : monitor
      int   last_cyc;
      int   seen_id;
      int   ref_c;
      exp_t e;
      last_cyc = 0;
      seen_id  = 0;
      forever begin
         @(negedge clk);
         if (os_tick) begin
            tick_seen++;
            ref_c    = (mark_id != seen_id) ? mark_cyc : last_cyc;
            seen_id  = mark_id;
            last_cyc = cyc;
            if (mid_tick)  mid_cyc  = cyc;
            if (baud_tick) baud_cyc = cyc;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_os_tick: got tick at cycle %0d os_count=%0d expected none", cyc, os_count);
            end else begin
               e = q.pop_front();
               chk_rng("os_interval", cyc - ref_c, e.lo, e.hi);
               chk("os_count", int'(os_count), e.cnt);
               chk("rate_cur", int'(rate_cur), e.rate);
               chk("rate_pend", int'(rate_pend), e.pend);
               chk("mid_tick", int'(mid_tick), int'(e.cnt == 8));
               chk("baud_tick", int'(baud_tick), int'(e.cnt == 0));
            end
         end else begin
            chk("stray_mid_baud", int'({mid_tick, baud_tick}), 0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mark();
      mark_cyc = cyc;
      mark_id++;
   endtask

   // Queue n expected os ticks; the first may have its own interval window.
   task automatic push(input int n, input int first_cnt, input int rate, input int pend,
                       input int lo1, input int hi1, input int lo, input int hi);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.lo   = (i == 0) ? lo1 : lo;
         e.hi   = (i == 0) ? hi1 : hi;
         e.cnt  = (first_cnt + i) % 16;
         e.rate = rate;
         e.pend = pend;
         q.push_back(e);
      end
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      @(posedge clk);
      while (q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d ticks outstanding expected 0", q.size());
         q.delete();
      end
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: got no end by cycle %0d expected finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t0;
      rst = 1'b1; valid = 1'b0; rate_sel = 2'd0; rate_load = 1'b0; resync = 1'b0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_os_tick", int'(os_tick), 0);
      chk("rst_mid_tick", int'(mid_tick), 0);
      chk("rst_baud_tick", int'(baud_tick), 0);
      chk("rst_os_count", int'(os_count), 0);
      chk("rst_rate_cur", int'(rate_cur), 3);
      chk("rst_rate_pend", int'(rate_pend), 0);

      // Rate 3 from reset: a full bit plus five more oversample ticks.
      step(); rst = 1'b0; valid = 1'b1; set_mark();
      push(21, 1, 3, 0, 55, 55, 54, 55);
      drain(1500);

      // Deferred switch to rate 0, loaded at os_count 5.
      rate_sel = 2'd0; rate_load = 1'b1;
      step(); rate_load = 1'b0;
      @(negedge clk);
      chk("load_pend_set", int'(rate_pend), 1);
      chk("load_rate_held", int'(rate_cur), 3);
      push(10, 6, 3, 1, 54, 55, 54, 55);
      push(1, 0, 0, 0, 54, 55, 54, 55);
      push(7, 1, 0, 0, 630, 652, 651, 652);
      drain(8000);

      // Freeze at os_count 7 for 500 cycles, then load rate 2 while idle.
      t0 = tick_seen;
      valid = 1'b0;
      repeat (500) step();
      @(negedge clk);
      chk("pause_os_count", int'(os_count), 7);
      chk("pause_tick_count", tick_seen - t0, 0);
      rate_sel = 2'd2; rate_load = 1'b1;
      step(); rate_load = 1'b0;
      @(negedge clk);
      chk("idle_load_rate", int'(rate_cur), 2);
      chk("idle_load_pend", int'(rate_pend), 0);
      step(); valid = 1'b1; set_mark();
      push(1, 8, 2, 0, 1, 109, 1, 109);
      drain(300);

      // Resync and load rate 1 in the same cycle.
      rate_sel = 2'd1; rate_load = 1'b1; resync = 1'b1;
      step(); rate_load = 1'b0; resync = 1'b0; set_mark();
      @(negedge clk);
      chk("rsl_rate_cur", int'(rate_cur), 1);
      chk("rsl_rate_pend", int'(rate_pend), 0);
      chk("rsl_os_count", int'(os_count), 0);
      chk("rsl_os_tick", int'(os_tick), 0);
      push(8, 1, 1, 0, 326, 326, 325, 326);
      drain(3000);

      // Back to rate 3 the same way, then a plain resync at os_count 3.
      rate_sel = 2'd3; rate_load = 1'b1; resync = 1'b1;
      step(); rate_load = 1'b0; resync = 1'b0; set_mark();
      push(3, 1, 3, 0, 55, 55, 54, 55);
      drain(400);
      resync = 1'b1;
      step(); resync = 1'b0; set_mark();
      @(negedge clk);
      chk("resync_os_count", int'(os_count), 0);
      chk("resync_rate_cur", int'(rate_cur), 3);
      push(16, 1, 3, 0, 55, 55, 54, 55);
      drain(1200);
      chk_rng("mid_after_resync", mid_cyc - mark_cyc, 433, 436);
      chk_rng("baud_after_resync", baud_cyc - mark_cyc, 867, 870);

      // Pending rate 2 is applied immediately by a resync.
      rate_sel = 2'd2; rate_load = 1'b1;
      step(); rate_load = 1'b0;
      @(negedge clk);
      chk("pend_before_resync", int'(rate_pend), 1);
      step(); resync = 1'b1;
      step(); resync = 1'b0; set_mark();
      @(negedge clk);
      chk("pend_resync_rate", int'(rate_cur), 2);
      chk("pend_resync_pend", int'(rate_pend), 0);
      chk("pend_resync_count", int'(os_count), 0);
      push(4, 1, 2, 0, 109, 109, 108, 109);
      drain(600);

      // Asynchronous reset between clock edges in the middle of a bit.
      repeat (50) step();
      #2 rst = 1'b1;
      #1;
      chk("arst_os_tick", int'(os_tick), 0);
      chk("arst_mid_tick", int'(mid_tick), 0);
      chk("arst_baud_tick", int'(baud_tick), 0);
      chk("arst_os_count", int'(os_count), 0);
      chk("arst_rate_cur", int'(rate_cur), 3);
      chk("arst_rate_pend", int'(rate_pend), 0);
      repeat (3) step();
      rst = 1'b0; set_mark();
      push(2, 1, 3, 0, 55, 55, 54, 55);
      drain(300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
